// File: rtl/fifo_oehb.sv
// Elastic FIFO with a fully registered consumer side (OEHB-style).
// Tokens are held in a circular array followed by an output register. The
// consumer-facing valid/data come straight from that register. ins_ready is
// decoded from the array occupancy only, so no input reaches any output
// through combinational logic.
module fifo_oehb #(
  parameter int NUM_SLOTS = 2,
  parameter int DATA_TYPE = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_TYPE-1:0] ins,
  input  logic                 ins_valid,
  input  logic                 outs_ready,
  output logic [DATA_TYPE-1:0] outs,
  output logic                 outs_valid,
  output logic                 ins_ready
);

  localparam int CW = $clog2(NUM_SLOTS + 1);
  localparam int PW = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(NUM_SLOTS);
  localparam logic [PW-1:0] LAST_PTR = PW'(NUM_SLOTS - 1);

  // Output register
  logic                 r_valid;
  logic [DATA_TYPE-1:0] r_data;

  // Storage array and its bookkeeping
  logic [DATA_TYPE-1:0] r_mem [NUM_SLOTS];
  logic [PW-1:0]        r_head;
  logic [PW-1:0]        r_tail;
  logic [CW-1:0]        r_count;

  // Per-cycle events
  logic w_ins_ready;
  logic w_fire;
  logic w_pop;
  logic w_load;
  logic w_from_mem;
  logic w_bypass;
  logic w_write;

  // Circular pointer increment; depth need not be a power of two.
  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    if (p == LAST_PTR) begin
      return {PW{1'b0}};
    end else begin
      return p + PW'(1);
    end
  endfunction

  // Handshake event decode; ready looks only at occupancy, never at a pop
  // in the same cycle, so the consumer-side ready never reaches ins_ready.
  always_comb begin
    w_ins_ready = 1'b0;
    w_fire      = 1'b0;
    w_pop       = 1'b0;
    w_load      = 1'b0;
    w_from_mem  = 1'b0;
    w_bypass    = 1'b0;
    w_write     = 1'b0;
    if (r_count < FULL_CNT) begin
      w_ins_ready = 1'b1;
    end else begin
      w_ins_ready = 1'b0;
    end
    w_fire     = ins_valid & w_ins_ready;
    w_pop      = r_valid & outs_ready;
    w_load     = ~r_valid | w_pop;
    w_from_mem = w_load & (r_count != {CW{1'b0}});
    w_bypass   = w_load & (r_count == {CW{1'b0}}) & w_fire;
    w_write    = w_fire & ~w_bypass;
  end

  // Array storage write; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (w_write) begin
      r_mem[r_tail] <= ins;
    end
  end

  // Head/tail pointers and occupancy count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head  <= {PW{1'b0}};
      r_tail  <= {PW{1'b0}};
      r_count <= {CW{1'b0}};
    end else begin
      if (w_write) begin
        r_tail <= next_ptr(r_tail);
      end
      if (w_from_mem) begin
        r_head <= next_ptr(r_head);
      end
      case ({w_write, w_from_mem})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Output register: refill from the array first, else bypass the input.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_data  <= {DATA_TYPE{1'b0}};
    end else if (w_from_mem) begin
      r_valid <= 1'b1;
      r_data  <= r_mem[r_head];
    end else if (w_bypass) begin
      r_valid <= 1'b1;
      r_data  <= ins;
    end else if (w_load) begin
      r_valid <= 1'b0;
    end
  end

  assign outs       = r_data;
  assign outs_valid = r_valid;
  assign ins_ready  = w_ins_ready;

endmodule

// File: tb/tb_fifo_oehb.sv
// Self-checking bench for fifo_oehb. Two instances (2 and 3 array slots)
// share the same stimulus; each is tracked by a token-queue model whose
// capacity is NUM_SLOTS+1 and whose head is what the consumer sees.
module tb_fifo_oehb;

  localparam int W  = 32;
  localparam int N2 = 2;
  localparam int N3 = 3;

  logic         clk;
  logic         rst;
  logic [W-1:0] ins;
  logic         ins_valid;
  logic         outs_ready;
  logic [W-1:0] outs2, outs3;
  logic         outs_valid2, outs_valid3;
  logic         ins_ready2, ins_ready3;

  int n_checks;
  int n_pass;

  logic [W-1:0] q2[$];
  logic [W-1:0] q3[$];
  logic [W-1:0] last2, last3;

  fifo_oehb #(.NUM_SLOTS(N2), .DATA_TYPE(W)) dut2 (
    .clk(clk), .rst(rst), .ins(ins), .ins_valid(ins_valid),
    .outs_ready(outs_ready), .outs(outs2), .outs_valid(outs_valid2),
    .ins_ready(ins_ready2)
  );

  fifo_oehb #(.NUM_SLOTS(N3), .DATA_TYPE(W)) dut3 (
    .clk(clk), .rst(rst), .ins(ins), .ins_valid(ins_valid),
    .outs_ready(outs_ready), .outs(outs3), .outs_valid(outs_valid3),
    .ins_ready(ins_ready3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Compare every output of both instances with the queue models.
  task automatic check_outputs();
    chk("valid2", {31'b0, outs_valid2}, {31'b0, (q2.size() > 0)});
    chk("ready2", {31'b0, ins_ready2},  {31'b0, (q2.size() <= N2)});
    chk("outs2",  outs2, (q2.size() > 0) ? q2[0] : last2);
    chk("valid3", {31'b0, outs_valid3}, {31'b0, (q3.size() > 0)});
    chk("ready3", {31'b0, ins_ready3},  {31'b0, (q3.size() <= N3)});
    chk("outs3",  outs3, (q3.size() > 0) ? q3[0] : last3);
  endtask

  // One clock: check, evaluate handshakes on pre-edge state, advance models.
  task automatic tick(output logic f2, output logic f3);
    logic p2, p3;
    check_outputs();
    f2 = ins_valid && (q2.size() <= N2);
    f3 = ins_valid && (q3.size() <= N3);
    p2 = outs_ready && (q2.size() > 0);
    p3 = outs_ready && (q3.size() > 0);
    @(posedge clk);
    #1;
    if (p2) void'(q2.pop_front());
    if (p3) void'(q3.pop_front());
    if (f2) q2.push_back(ins);
    if (f3) q3.push_back(ins);
    if (q2.size() > 0) last2 = q2[0];
    if (q3.size() > 0) last3 = q3[0];
  endtask

  // Asynchronous reset pulse placed between clock edges.
  task automatic do_reset();
    rst = 1'b1;
    #1;
    q2.delete();
    q3.delete();
    last2 = '0;
    last3 = '0;
    check_outputs();
    #1;
    rst = 1'b0;
  endtask

  initial begin
    logic f2, f3;
    int   tok;
    int   guard;
    n_checks   = 0;
    n_pass     = 0;
    last2      = '0;
    last3      = '0;
    rst        = 1'b1;
    ins        = '0;
    ins_valid  = 1'b0;
    outs_ready = 1'b0;
    #3;
    check_outputs();
    #4;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // T1: reset mid-stream with two tokens held
    outs_ready = 1'b0;
    ins_valid  = 1'b1;
    ins = 32'h11; tick(f2, f3);
    ins = 32'h22; tick(f2, f3);
    ins_valid = 1'b0;
    chk("t1_held_valid", {31'b0, outs_valid2}, 32'd1);
    do_reset();
    chk("t1_rst_valid", {31'b0, outs_valid2}, 32'd0);
    chk("t1_rst_outs",  outs2, 32'd0);
    chk("t1_rst_ready", {31'b0, ins_ready2}, 32'd1);
    outs_ready = 1'b1;
    tick(f2, f3);
    chk("t1_tokens_lost", {31'b0, outs_valid2}, 32'd0);

    // T2: single-cycle latency through an empty buffer
    ins = 32'hA5; ins_valid = 1'b1; outs_ready = 1'b1;
    tick(f2, f3);
    ins_valid = 1'b0;
    chk("t2_outs",  outs2, 32'hA5);
    chk("t2_valid", {31'b0, outs_valid2}, 32'd1);
    tick(f2, f3);
    chk("t2_ready", {31'b0, ins_ready2}, 32'd1);

    // T3: fill with the consumer stalled, then drain in order
    do_reset();
    outs_ready = 1'b0;
    ins_valid  = 1'b1;
    for (int v = 1; v <= 3; v++) begin
      ins = W'(v);
      tick(f2, f3);
      chk("t3_accept", {31'b0, f2}, 32'd1);
    end
    chk("t3_full_ready", {31'b0, ins_ready2}, 32'd0);
    ins = 32'h4;
    tick(f2, f3);
    chk("t3_reject", {31'b0, f2}, 32'd0);
    outs_ready = 1'b1;
    guard = 0;
    f2 = 1'b0;
    while (!f2 && guard < 20) begin
      tick(f2, f3);
      guard++;
    end
    chk("t3_accept4", {31'b0, f2}, 32'd1);
    ins_valid = 1'b0;
    for (int i = 0; i < 6; i++) tick(f2, f3);
    chk("t3_drained", {31'b0, outs_valid2}, 32'd0);
    chk("t3_last",    outs2, 32'h4);

    // T4: continuous stream, one token per cycle through the bypass
    do_reset();
    outs_ready = 1'b1;
    ins_valid  = 1'b1;
    for (int v = 0; v < 100; v++) begin
      ins = W'(v);
      tick(f2, f3);
      chk("t4_accept", {31'b0, f2}, 32'd1);
      chk("t4_outs", outs2, W'(v));
    end
    ins_valid = 1'b0;
    tick(f2, f3);
    chk("t4_empty", {31'b0, outs_valid2}, 32'd0);

    // T5: random handshakes, 1000 tokens through the 3-slot instance
    do_reset();
    tok   = 0;
    guard = 0;
    while (tok < 1000 && guard < 20000) begin
      ins        = 32'h5000_0000 + W'(tok);
      ins_valid  = 1'($urandom_range(0, 1));
      outs_ready = 1'($urandom_range(0, 1));
      tick(f2, f3);
      if (f3) tok++;
      guard++;
    end
    chk("t5_all_sent", W'(tok), 32'd1000);
    ins_valid  = 1'b0;
    outs_ready = 1'b1;
    for (int i = 0; i < 8; i++) tick(f2, f3);
    chk("t5_drained", {31'b0, outs_valid3}, 32'd0);

    // T6: pop and push offered together while full
    do_reset();
    outs_ready = 1'b0;
    ins_valid  = 1'b1;
    for (int v = 0; v < 3; v++) begin
      ins = 32'h60 + W'(v);
      tick(f2, f3);
    end
    ins = 32'h66;
    outs_ready = 1'b1;
    chk("t6_full_ready", {31'b0, ins_ready2}, 32'd0);
    tick(f2, f3);
    chk("t6_no_accept", {31'b0, f2}, 32'd0);
    chk("t6_popped",    outs2, 32'h61);
    chk("t6_reready",   {31'b0, ins_ready2}, 32'd1);
    tick(f2, f3);
    chk("t6_accept", {31'b0, f2}, 32'd1);
    ins_valid = 1'b0;
    for (int i = 0; i < 6; i++) tick(f2, f3);
    chk("t6_last", outs2, 32'h66);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
